// File: rtl/act_dispatch_if.sv
// Beat stream from the activation source plus the per-row valid/req bundle
// feeding the superblock row.
interface act_dispatch_if #(
  parameter int N_ROW   = 12,
  parameter int WID_ACT = 16
);
  logic [2*WID_ACT-1:0]       in_data;
  logic                       in_vld;
  logic                       in_rdy;
  logic [2*WID_ACT*N_ROW-1:0] act_data_in;
  logic [N_ROW-1:0]           act_data_in_vld;
  logic [N_ROW-1:0]           act_data_in_req;

  // master: source and superblock side; slave: the dispatcher
  modport master (
    output in_data, in_vld, act_data_in_req,
    input  in_rdy, act_data_in, act_data_in_vld
  );

  modport slave (
    input  in_data, in_vld, act_data_in_req,
    output in_rdy, act_data_in, act_data_in_vld
  );
endinterface

// File: rtl/act_dispatch.sv
// Activation dispatcher: spreads one beat stream in fixed-length bursts,
// round-robin over the enabled superblock rows, one output register per row.
module act_dispatch #(
  parameter int N_ROW     = 12,
  parameter int WID_ACT   = 16,
  parameter int WID_BURST = 8,
  parameter int WID_ROUND = 8
) (
  input  logic                 clk_l,
  input  logic                 rst_n,
  act_dispatch_if.slave        bus,
  input  logic                 cfg_start,
  input  logic [N_ROW-1:0]     cfg_row_mask,
  input  logic [WID_BURST-1:0] cfg_burst_len,
  input  logic [WID_ROUND-1:0] cfg_rounds,
  output logic                 busy,
  output logic                 done
);
  localparam int WID_BEAT = 2*WID_ACT;
  localparam int WID_ROW  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
  localparam logic [WID_BURST-1:0] BURST_ONE = WID_BURST'(1);
  localparam logic [WID_ROUND-1:0] ROUND_ONE = WID_ROUND'(1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, FIN} state_t;

  state_t                   state, state_nxt;
  logic [N_ROW-1:0]         mask;
  logic [WID_BURST-1:0]     burst_len;
  logic [WID_ROUND-1:0]     rounds;
  logic [WID_BURST-1:0]     word_cnt, word_cnt_nxt;
  logic [WID_ROUND-1:0]     round_cnt, round_cnt_nxt;
  logic [WID_ROW-1:0]       cur, cur_nxt;
  logic [WID_ROW-1:0]       first_row, next_row;
  logic                     next_wraps;
  logic                     cfg_zero, accept, burst_last, round_last;
  logic [WID_BEAT-1:0]      row_data [N_ROW];
  logic [N_ROW-1:0]         row_vld;
  logic [N_ROW-1:0]         row_load;
  logic [WID_BEAT*N_ROW-1:0] data_flat;

  assign cfg_zero   = (cfg_row_mask == '0) || (cfg_burst_len == '0) || (cfg_rounds == '0);
  assign burst_last = (word_cnt == burst_len - BURST_ONE);
  assign round_last = (round_cnt == rounds - ROUND_ONE);

  // The current row can take a beat when its register is empty or emptying now
  assign bus.in_rdy = (state == SEND) && (!row_vld[cur] || bus.act_data_in_req[cur]);
  assign accept     = bus.in_vld && bus.in_rdy;

  always_comb begin
    first_row = '0;
    for (int r = N_ROW-1; r >= 0; r--)
      if (cfg_row_mask[r]) first_row = WID_ROW'(r);
  end

  // Next enabled row above cur; falling back to the lowest one is a wrap
  always_comb begin
    next_row   = cur;
    next_wraps = 1'b1;
    for (int r = N_ROW-1; r >= 0; r--)
      if (mask[r]) next_row = WID_ROW'(r);
    for (int r = N_ROW-1; r >= 0; r--)
      if (mask[r] && (WID_ROW'(r) > cur)) begin
        next_row   = WID_ROW'(r);
        next_wraps = 1'b0;
      end
  end

  always_comb begin
    state_nxt     = state;
    word_cnt_nxt  = word_cnt;
    round_cnt_nxt = round_cnt;
    cur_nxt       = cur;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          word_cnt_nxt  = '0;
          round_cnt_nxt = '0;
          cur_nxt       = first_row;
          state_nxt     = cfg_zero ? FIN : SEND;
        end
      end
      SEND: begin
        if (accept) begin
          if (burst_last) begin
            word_cnt_nxt = '0;
            cur_nxt      = next_row;
            if (next_wraps) begin
              round_cnt_nxt = round_cnt + ROUND_ONE;
              if (round_last) state_nxt = DRAIN;
            end
          end else begin
            word_cnt_nxt = word_cnt + BURST_ONE;
          end
        end
      end
      DRAIN: begin
        if (row_vld == '0) state_nxt = FIN;
      end
      FIN: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      word_cnt  <= '0;
      round_cnt <= '0;
      cur       <= '0;
      mask      <= '0;
      burst_len <= '0;
      rounds    <= '0;
    end else begin
      state     <= state_nxt;
      word_cnt  <= word_cnt_nxt;
      round_cnt <= round_cnt_nxt;
      cur       <= cur_nxt;
      if ((state == IDLE) && cfg_start) begin
        mask      <= cfg_row_mask;
        burst_len <= cfg_burst_len;
        rounds    <= cfg_rounds;
      end
    end
  end

  always_comb begin
    row_load = '0;
    if (accept) row_load[cur] = 1'b1;
  end

  // Data only moves on a load, so it stays put while valid waits for req
  always_ff @(posedge clk_l or negedge rst_n) begin
    if (!rst_n) begin
      row_vld <= '0;
      for (int r = 0; r < N_ROW; r++) row_data[r] <= '0;
    end else begin
      for (int r = 0; r < N_ROW; r++) begin
        if (row_load[r]) begin
          row_data[r] <= bus.in_data;
          row_vld[r]  <= 1'b1;
        end else if (bus.act_data_in_req[r]) begin
          row_vld[r]  <= 1'b0;
        end
      end
    end
  end

  always_comb begin
    data_flat = '0;
    for (int r = 0; r < N_ROW; r++) data_flat[r*WID_BEAT +: WID_BEAT] = row_data[r];
  end

  assign bus.act_data_in     = data_flat;
  assign bus.act_data_in_vld = row_vld;
  assign busy                = (state != IDLE);
  assign done                = (state == FIN);
endmodule
